// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master bridge and its slave-side bench:
//   - apb_state_e : bridge FSM state encoding (2-bit)
//   - APB_ADDR_W / APB_DATA_W : default bus widths
//   - apb_txn_t   : one command {write, addr, wdata}
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_txn_t;

endpackage

// File: rtl/apb_master_bridge.sv
// ----------------------------------------------------------------------------
// apb_master_bridge
// Upstream APB requester: takes one command at a time from a valid/ready
// command port, runs the APB SETUP/ACCESS phases and returns completion
// plus read data on a valid/ready response port.
//
// Optional build macro: APB_MASTER_TIMEOUT_EN
//   defined   : ACCESS aborts after TIMEOUT_CYC cycles without pready,
//               answering with rsp_err=1, rsp_rdata=0.
//   undefined : wait states are unbounded, rsp_err is tied 0.
//
// Ports
//   pclk, rst_n                  clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata  command request
//   rsp_valid/ready/rdata/err         response
//   paddr/psel/penable/pwrite/pwdata  APB request side
//   pready/prdata                     APB completion side
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cmd_ready=1, waiting for a command
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout)
// RESP   | rsp_valid=1 until the requester takes the response
// ----------------------------------------------------------------------------
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    apb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_err_q,  rsp_err_d;
    logic             expired;

    // Count has reached its last allowed ACCESS cycle; if pready is still
    // low at this edge the transfer is abandoned.
    assign expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC has no effect in this build.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ACCESS: begin
                if (pready) begin
                    // Write completions never forward whatever the slave
                    // happens to drive on prdata.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (expired) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge
// Drives apb_master_bridge with directed and randomized commands against an
// APB memory slave model, and checks responses/timing against a reference
// memory and the bridge's documented latency rules.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TMO_CYC = 16;
    localparam int BUDGET  = 200;

    logic          pclk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;

    apb_master_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO_CYC)
    ) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Environment: memory slave with a programmable number of wait states,
    // preloaded with mem[a] = a.
    logic [DW-1:0] slave_mem [256];
    int            waits_cfg = 0;
    int            slv_wait  = 0;

    // Reference model: what the memory should hold after accepted writes.
    logic [DW-1:0] ref_mem [256];

    initial begin
        pready = 1'b0;
        prdata = '0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                if (slv_wait < waits_cfg) begin
                    pready = 1'b0;
                    slv_wait++;
                end else begin
                    pready = 1'b1;
                    prdata = pwrite ? $urandom : slave_mem[paddr];
                end
            end else begin
                pready   = 1'b0;
                slv_wait = 0;
                prdata   = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(posedge pclk);
            if (psel && penable && pready && pwrite) slave_mem[paddr] = pwdata;
        end
    end

    // One full command/response exchange. rsp_hold cycles of back-pressure
    // are applied with a competing command presented the whole time.
    task automatic do_txn(input apb_txn_t t, input int waits, input int rsp_hold);
        bit            tmo;
        int            exp_k;
        logic [DW-1:0] exp_rdata;
        int            cyc;
        int            acc;
        bit            stable_ok;
        bit            got_rsp;
        bit            hold_ok;
        logic [DW-1:0] held_rdata;
        int            budget;

        tmo = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo = (waits >= TMO_CYC);
`endif
        exp_k     = tmo ? TMO_CYC : waits + 1;
        exp_rdata = (tmo || t.write) ? '0 : ref_mem[t.addr];
        if (!tmo && t.write) ref_mem[t.addr] = t.wdata;

        waits_cfg = waits;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_valid = 1'b1;

        budget = 0;
        while (!cmd_ready && budget < BUDGET) begin
            @(posedge pclk); #1;
            budget++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end

        @(posedge pclk); #1;             // accept edge N, now in N+1
        cmd_valid = 1'b0;
        chk("setup_psel",    32'(psel),    32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_paddr",   32'(paddr),   32'(t.addr));
        chk("setup_pwrite",  32'(pwrite),  32'(t.write));
        if (t.write) chk("setup_pwdata", pwdata, t.wdata);

        cyc = 1; acc = 0; stable_ok = 1'b1; got_rsp = 1'b0;
        while (cyc < BUDGET + TMO_CYC) begin
            @(posedge pclk); #1;
            cyc++;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                break;
            end
            acc++;
            if (!(psel && penable && paddr == t.addr && pwrite == t.write &&
                  (!t.write || pwdata == t.wdata)))
                stable_ok = 1'b0;
        end
        chk("rsp_seen", 32'(got_rsp), 32'd1);
        if (!got_rsp) return;

        chk("access_stable",  32'(stable_ok), 32'd1);
        chk("access_cycles",  32'(acc),       32'(exp_k));
        chk("rsp_latency",    32'(cyc),       32'(exp_k + 2));
        chk("rsp_rdata",      rsp_rdata,      exp_rdata);
        chk("rsp_err",        32'(rsp_err),   32'(tmo));
        chk("rsp_psel_low",   32'({psel, penable}), 32'd0);

        hold_ok    = 1'b1;
        held_rdata = rsp_rdata;
        if (rsp_hold > 0) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = AW'($urandom);
        end
        for (int i = 0; i < rsp_hold; i++) begin
            @(posedge pclk); #1;
            if (!(rsp_valid && !cmd_ready && !psel && rsp_rdata == held_rdata &&
                  rsp_err == tmo))
                hold_ok = 1'b0;
        end
        if (rsp_hold > 0) chk("rsp_backpressure", 32'(hold_ok), 32'd1);

        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_done_ready", 32'(cmd_ready), 32'd1);
        chk("rsp_done_psel",  32'(psel),      32'd0);
    endtask

    apb_txn_t t;
    bit       quiet_ok;

    initial begin
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = DW'(i);
            ref_mem[i]   = DW'(i);
        end
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge pclk);
        #1;
        chk("rst_outputs", 32'({psel, penable, pwrite, rsp_valid, rsp_err}), 32'd0);
        chk("rst_paddr",   32'(paddr), 32'd0);
        chk("rst_pwdata",  pwdata,     32'd0);
        chk("rst_rdata",   rsp_rdata,  32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        @(posedge pclk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        t = '{write: 1'b1, addr: 8'h10, wdata: 32'hDEADBEEF};
        do_txn(t, 0, 0);
        t = '{write: 1'b0, addr: 8'h10, wdata: 32'h0};
        do_txn(t, 0, 0);
        t = '{write: 1'b0, addr: 8'h05, wdata: 32'h0};
        do_txn(t, 3, 0);
        t = '{write: 1'b0, addr: 8'h10, wdata: 32'h0};
        do_txn(t, 1, 5);
        t = '{write: 1'b1, addr: 8'h22, wdata: 32'h12345678};
        do_txn(t, 0, 0);

        // Reset in the middle of ACCESS
        waits_cfg = 6;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        cmd_valid = 1'b1;
        @(posedge pclk); #1;            // accepted
        cmd_valid = 1'b0;
        @(posedge pclk); #1;            // ACCESS
        @(posedge pclk); #1;            // still ACCESS (waiting)
        chk("pre_rst_access", 32'({psel, penable}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_apb",   32'({psel, penable}), 32'd0);
        chk("async_rst_rsp",   32'(rsp_valid),       32'd0);
        chk("async_rst_rdata", rsp_rdata,            32'd0);
        @(negedge pclk);
        rst_n = 1'b1;
        waits_cfg = 0;
        @(posedge pclk); #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        quiet_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge pclk); #1;
            if (rsp_valid || psel) quiet_ok = 1'b0;
        end
        chk("post_rst_no_rsp", 32'(quiet_ok), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            t.write = 1'($urandom_range(0, 1));
            t.addr  = AW'($urandom_range(0, 255));
            t.wdata = $urandom;
            do_txn(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

`ifdef APB_MASTER_TIMEOUT_EN
        t = '{write: 1'b0, addr: 8'h33, wdata: 32'h0};
        do_txn(t, 1000, 0);
        t = '{write: 1'b1, addr: 8'h34, wdata: 32'hCAFEF00D};
        do_txn(t, 1000, 0);
        t = '{write: 1'b0, addr: 8'h34, wdata: 32'h0};
        do_txn(t, TMO_CYC - 1, 0);
        t = '{write: 1'b0, addr: 8'h10, wdata: 32'h0};
        do_txn(t, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
